// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit: FSM states,
// trap causes and trap vector addresses.
package pc_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  // External codes 0..2 map directly; code 3 is free for the internal misaligned cause
  typedef enum logic [1:0] {
    CAUSE_BAD_OP   = 2'd0,
    CAUSE_OVERFLOW = 2'd1,
    CAUSE_DIV_ZERO = 2'd2,
    CAUSE_MISALIGN = 2'd3
  } cause_t;

  localparam logic [XLEN-1:0] VEC_BAD_OP   = 32'h0000_0100;
  localparam logic [XLEN-1:0] VEC_OVERFLOW = 32'h0000_0104;
  localparam logic [XLEN-1:0] VEC_DIV_ZERO = 32'h0000_0108;
  localparam logic [XLEN-1:0] VEC_MISALIGN = 32'h0000_010C;

  // Reserved external cause 3 is handled as a bad opcode
  function automatic cause_t map_cause(input logic [1:0] raw);
    return (raw == 2'd3) ? CAUSE_BAD_OP : cause_t'(raw);
  endfunction

  function automatic logic [XLEN-1:0] trap_vector(input cause_t cause);
    case (cause)
      CAUSE_OVERFLOW: return VEC_OVERFLOW;
      CAUSE_DIV_ZERO: return VEC_DIV_ZERO;
      CAUSE_MISALIGN: return VEC_MISALIGN;
      default:        return VEC_BAD_OP;
    endcase
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the datapath/fetch side and the PC unit.
interface pc_unit_if;
  import pc_unit_pkg::*;

  logic [XLEN-1:0] pc_next;
  logic            pc_write;
  logic            pc_write_cond;
  logic            branch_ne;
  logic            alu_zero;
  logic            instr_done;
  logic            exc_req;
  logic [1:0]      exc_cause;
  logic            fetch_req;
  logic            fetch_ack;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] instr_count;
  logic [1:0]      state;

  modport master (
    output pc_next, pc_write, pc_write_cond, branch_ne, alu_zero,
           instr_done, exc_req, exc_cause, fetch_ack,
    input  fetch_req, pc, epc, instr_count, state
  );

  modport slave (
    input  pc_next, pc_write, pc_write_cond, branch_ne, alu_zero,
           instr_done, exc_req, exc_cause, fetch_ack,
    output fetch_req, pc, epc, instr_count, state
  );
endinterface

// File: rtl/pc_unit_branch_cond.sv
// PC write enable: unconditional write, or branch taken (beq on zero, bne on non-zero).
module branch_cond (
  input  logic pc_write,
  input  logic pc_write_cond,
  input  logic branch_ne,
  input  logic alu_zero,
  output logic write_en
);
  assign write_en = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch handshake, PC update/branching, exception
// trapping to fixed vectors, and retired-instruction counting.
module pc_unit
  import pc_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  pc_unit_if.slave bus
);

  state_t          state_q, state_d;
  cause_t          cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            fetch_req_q, fetch_req_d;
  logic            write_en;

  branch_cond u_branch_cond (
    .pc_write      (bus.pc_write),
    .pc_write_cond (bus.pc_write_cond),
    .branch_ne     (bus.branch_ne),
    .alu_zero      (bus.alu_zero),
    .write_en      (write_en)
  );

  // State and datapath registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_BAD_OP;
      pc_q        <= '0;
      pc_fetch_q  <= '0;
      epc_q       <= '0;
      count_q     <= '0;
      fetch_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      pc_fetch_q  <= pc_fetch_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
      fetch_req_q <= fetch_req_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    pc_d       = pc_q;
    pc_fetch_d = pc_fetch_q;
    epc_d      = epc_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (bus.fetch_ack) begin
          pc_fetch_d = pc_q;
          pc_d       = pc_q + XLEN'(PC_STEP);
          state_d    = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (bus.exc_req) begin
          cause_d = map_cause(bus.exc_cause);
          state_d = ST_TRAP;
        end else if (write_en) begin
          if (bus.pc_next[1:0] != 2'b00) begin
            cause_d = CAUSE_MISALIGN;
            state_d = ST_TRAP;
          end else begin
            pc_d    = bus.pc_next;
            count_d = count_q + XLEN'(1);
            state_d = ST_FETCH;
          end
        end else if (bus.instr_done) begin
          count_d = count_q + XLEN'(1);
          state_d = ST_FETCH;
        end
      end

      ST_TRAP: begin
        epc_d   = pc_fetch_q;
        pc_d    = trap_vector(cause_q);
        state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase

    // Moore fetch request: registered copy of "next state is FETCH"
    fetch_req_d = (state_d == ST_FETCH);
  end

  assign bus.fetch_req   = fetch_req_q;
  assign bus.pc          = pc_q;
  assign bus.epc         = epc_q;
  assign bus.instr_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state changes on rising edge.
REQ-002 SHALL have: reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: pc_next  in  32  next-PC value from the PC-source mux output.
REQ-004 SHALL have: pc_write  in  1  unconditional PC write.
REQ-005 SHALL have: pc_write_cond  in  1  conditional PC write (branch).
REQ-006 SHALL have: branch_ne  in  1  0 = write when alu_zero=1 (beq), 1 = write when alu_zero=0 (bne).
REQ-007 SHALL have: alu_zero  in  1  ALU zero flag.
REQ-008 SHALL have: instr_done  in  1  current instruction finished without a PC redirect.
REQ-009 SHALL have: exc_req  in  1  exception request; exc_cause  in  2  (0 bad opcode, 1 overflow, 2 divide-by-zero, 3 reserved, treated as 0).
REQ-010 SHALL have: fetch_req  out  1  instruction fetch request at pc; fetch_ack  in  1  fetch complete.
REQ-011 SHALL have: pc  out  32; epc  out  32; instr_count  out  32  retired-instruction counter; state  out  2  current FSM state.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, EXEC, TRAP.
REQ-013 IDLE SHALL go to FETCH after one cycle.
REQ-014 FETCH SHALL hold fetch_req=1 (registered, Moore); stay in FETCH until fetch_ack=1.
REQ-015 On fetch_ack in FETCH: pc_fetch <= pc, pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), go to EXEC.
REQ-016 In EXEC, priority SHALL be: exc_req > PC write > instr_done > hold.
REQ-017 PC write in EXEC SHALL occur when pc_write=1, or when pc_write_cond=1 and (alu_zero XOR branch_ne)=1; pc <= pc_next; go to FETCH; instr_count += 1.
REQ-018 PC write with pc_next[1:0]!=0 SHALL NOT load pc; SHALL trap with internal misaligned cause instead.
REQ-019 instr_done=1 with no write in EXEC SHALL go to FETCH with pc unchanged; instr_count += 1.
REQ-020 exc_req=1 in EXEC SHALL go to TRAP; simultaneous pc_write/instr_done ignored; instr_count unchanged.
REQ-021 TRAP SHALL last one cycle: epc <= pc_fetch; pc <= vector(cause); go to FETCH.
REQ-022 Vectors SHALL be: bad opcode 0x0000_0100, overflow 0x0000_0104, divide-by-zero 0x0000_0108, misaligned 0x0000_010C.
REQ-023 pc_write, pc_write_cond, instr_done, exc_req SHALL be ignored outside EXEC; fetch_ack SHALL be ignored outside FETCH.
REQ-024 instr_count SHALL wrap 0xFFFF_FFFF -> 0.
REQ-025 fetch_req SHALL deassert in the cycle after fetch_ack is accepted.

Reset
REQ-026 reset_n=0 at a clock edge SHALL set pc=0, epc=0, pc_fetch=0, instr_count=0, fetch_req=0, state=IDLE, overriding every other input in any state.
REQ-027 Reset asserted mid-fetch or in TRAP SHALL abandon the operation; no partial epc/pc update.

Structure
REQ-028 State encoding, exception-cause codes and the four vector constants SHALL live in a shared package (pc_unit_pkg).
REQ-029 Branch-condition evaluation SHALL be a sub-module branch_cond (pc_write, pc_write_cond, branch_ne, alu_zero -> write_en); the rest is flat.

Verification
REQ-030 Reset, then fetch_ack after 2 wait cycles -> fetch_req=1 for 3 cycles, pc 0->4, state EXEC.
REQ-031 EXEC at pc=0x40, pc_write_cond=1, branch_ne=0, alu_zero=1, pc_next=0x80 -> pc=0x80, FETCH, instr_count+1; repeat alu_zero=0 -> pc stays 0x40.
REQ-032 EXEC after fetching 0x200, exc_req=1 with pc_write=1, exc_cause=1 -> epc=0x200, pc=0x104, instr_count unchanged.
REQ-033 EXEC after fetching 0x300, pc_write=1, pc_next=0x0000_0102 -> TRAP, epc=0x300, pc=0x10C.
REQ-034 pc=0xFFFF_FFFC fetched -> pc=0; instr_count preset via 0xFFFF_FFFF retirements (or force) -> wraps to 0.
REQ-035 reset_n=0 for one cycle while in FETCH with fetch_ack=1 -> next state IDLE, pc=0, fetch_req=0.
